// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared sizing constants and controller state encoding for the 256x84
// single-port SRAM controller and its arbiter.
package ct_spsram_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 84;
    localparam int unsigned DEPTH          = 256;

    // Request/grant bit positions shared by the controller and the arbiter.
    localparam int unsigned ARB_RD = 0;
    localparam int unsigned ARB_WR = 1;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_rr_arb2.sv
// Two-requester round-robin arbiter with combinational one-hot grants and a
// registered pointer that remembers which port was granted last.
module ct_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant selection; on contention the port not granted last wins.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (last_q) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
            end
            default: gnt_o = 2'b00;
        endcase
        if (adv_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer; reset marks port 1 as last so port 0 goes first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ct_spsram_256x84_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset, then
// arbitrates read and write requesters onto the one SRAM port.
module ct_spsram_256x84_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  run_s;
    logic [1:0]            arb_req_s;
    logic [1:0]            arb_gnt_s;

    // Requests are only visible to the arbiter in RUN and outside reset.
    assign run_s     = (state_q == RUN) && !RST;
    assign arb_req_s = run_s ? {wr_req, rd_req} : 2'b00;

    ct_rr_arb2 u_arb (
        .clk_i (CLK),
        .rst_i (RST),
        .req_i (arb_req_s),
        .adv_i (run_s),
        .gnt_o (arb_gnt_s)
    );

    assign rd_gnt      = arb_gnt_s[ARB_RD];
    assign wr_gnt      = arb_gnt_s[ARB_WR];
    assign rd_data     = sram_Q;
    assign rd_data_vld = rd_vld_q && !RST;
    assign init_done   = (state_q == RUN) && !RST;

    // Next-state, sweep counter and SRAM pin drive.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_vld_d  = rd_gnt;
        sram_A    = '0;
        sram_CEN  = 1'b1;
        sram_GWEN = 1'b1;
        sram_WEN  = '1;
        sram_D    = '0;
        if (RST) begin
            state_d  = INIT;
            cnt_d    = '0;
            rd_vld_d = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sram_A    = cnt_q;
                    sram_CEN  = 1'b0;
                    sram_GWEN = 1'b0;
                    sram_WEN  = '0;
                    sram_D    = '0;
                    cnt_d     = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = RUN;
                    end else begin
                        state_d = INIT;
                    end
                end
                RUN: begin
                    if (wr_gnt) begin
                        sram_A    = wr_addr;
                        sram_CEN  = 1'b0;
                        sram_GWEN = 1'b0;
                        sram_WEN  = ~wr_bmask;
                        sram_D    = wr_data;
                    end else if (rd_gnt) begin
                        sram_A    = rd_addr;
                        sram_CEN  = 1'b0;
                        sram_GWEN = 1'b1;
                        sram_WEN  = '1;
                    end else begin
                        sram_CEN  = 1'b1;
                    end
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, sweep counter and read-valid registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= rd_vld_d;
        end
    end

endmodule

// File: tb/tb_ct_spsram_256x84_ctrl.sv
// Randomized scoreboard bench for ct_spsram_256x84_ctrl with a behavioural
// SRAM and a reference memory/arbitration model.
module tb_ct_spsram_256x84_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wr_req, rd_req;
    logic [7:0]  wr_addr, rd_addr;
    logic [83:0] wr_data, wr_bmask;
    logic        wr_gnt, rd_gnt, rd_data_vld, init_done;
    logic [83:0] rd_data;
    logic [7:0]  sram_A;
    logic        sram_CEN, sram_GWEN;
    logic [83:0] sram_WEN, sram_D, sram_Q;

    int checks = 0;
    int errors = 0;

    logic [83:0] mem     [256];
    logic [83:0] ref_mem [256];
    logic [83:0] exp_q [$];
    int          init_cnt;
    bit          m_last_wr;
    bit          prev_rd;

    ct_spsram_256x84_ctrl dut (
        .CLK(CLK), .RST(RST),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bmask(wr_bmask), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data), .init_done(init_done),
        .sram_A(sram_A), .sram_CEN(sram_CEN), .sram_GWEN(sram_GWEN),
        .sram_WEN(sram_WEN), .sram_D(sram_D), .sram_Q(sram_Q)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: bit-masked write, Q registered one cycle after a read.
    always @(posedge CLK) begin
        if (sram_CEN === 1'b0) begin
            if (sram_GWEN === 1'b0) begin
                mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
            end else begin
                sram_Q <= mem[sram_A];
            end
        end
    end

    function automatic logic [83:0] rand84();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[83:0];
    endfunction

    task automatic chkw(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid read beat must match the oldest expected read.
    always @(negedge CLK) begin
        if (rd_data_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data: valid with no read outstanding, got %h expected none", rd_data);
            end else begin
                chkw("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic issue_wr(input logic [7:0] a, input logic [83:0] d, input logic [83:0] m);
        wr_addr = a; wr_data = d; wr_bmask = m; wr_req = 1'b1;
    endtask

    task automatic issue_rd(input logic [7:0] a);
        rd_addr = a; rd_req = 1'b1;
    endtask

    // One clock: check outputs against the model, advance model, drop granted requests.
    task automatic do_cycle();
        bit e_rd, e_wr, run;
        @(negedge CLK);
        run  = (RST == 1'b0) && (init_cnt >= 256);
        e_rd = 1'b0;
        e_wr = 1'b0;
        if (run) begin
            if (rd_req && wr_req) begin
                e_rd = m_last_wr;
                e_wr = !m_last_wr;
            end else begin
                e_rd = rd_req;
                e_wr = wr_req;
            end
        end
        chk1("rd_gnt", rd_gnt, e_rd);
        chk1("wr_gnt", wr_gnt, e_wr);
        chk1("init_done", init_done, run);
        chk1("rd_data_vld", rd_data_vld, !RST && prev_rd);
        if (RST) begin
            chk1("rst_cen", sram_CEN, 1'b1);
        end else if (!run) begin
            chkw("init_A", 84'(sram_A), 84'(init_cnt));
            chkw("init_ctl", {82'd0, sram_CEN, sram_GWEN}, 84'd0);
            chkw("init_WEN", sram_WEN, 84'd0);
            chkw("init_D", sram_D, 84'd0);
        end else if (e_wr) begin
            chkw("wr_A", 84'(sram_A), 84'(wr_addr));
            chkw("wr_ctl", {82'd0, sram_CEN, sram_GWEN}, 84'd0);
            chkw("wr_WEN", sram_WEN, ~wr_bmask);
            chkw("wr_D", sram_D, wr_data);
        end else if (e_rd) begin
            chkw("rd_A", 84'(sram_A), 84'(rd_addr));
            chkw("rd_ctl", {82'd0, sram_CEN, sram_GWEN}, 84'd1);
            chkw("rd_WEN", sram_WEN, {84{1'b1}});
        end else begin
            chkw("idle_A", 84'(sram_A), 84'd0);
            chkw("idle_ctl", {82'd0, sram_CEN, sram_GWEN}, 84'd3);
            chkw("idle_WEN", sram_WEN, {84{1'b1}});
            chkw("idle_D", sram_D, 84'd0);
        end
        if (RST) begin
            init_cnt  = 0;
            m_last_wr = 1'b1;
            prev_rd   = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 256; i++) ref_mem[i] = 84'd0;
        end else begin
            if (init_cnt < 256) init_cnt++;
            if (e_wr) begin
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
                m_last_wr = 1'b1;
            end
            if (e_rd) begin
                exp_q.push_back(ref_mem[rd_addr]);
                m_last_wr = 1'b0;
            end
            prev_rd = e_rd;
        end
        @(posedge CLK);
        #1;
        if (e_wr) wr_req = 1'b0;
        if (e_rd) rd_req = 1'b0;
    endtask

    // Let outstanding requests complete within a bounded number of cycles.
    task automatic drain();
        for (int i = 0; i < 10 && (wr_req || rd_req); i++) do_cycle();
        if (wr_req || rd_req) begin
            checks++;
            errors++;
            $display("FAIL drain: requests still pending wr=%b rd=%b expected none", wr_req, rd_req);
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        do_cycle();
        do_cycle();
    endtask

    initial begin
        RST = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = 8'd0; rd_addr = 8'd0; wr_data = 84'd0; wr_bmask = 84'd0;
        sram_Q = 84'd0;
        init_cnt = 0; m_last_wr = 1'b1; prev_rd = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = rand84();
        repeat (3) do_cycle();

        // Sweep with both requests held: no grants, addresses 0..255.
        RST = 1'b0;
        issue_wr(8'($urandom_range(0, 255)), rand84(), rand84());
        issue_rd(8'($urandom_range(0, 255)));
        repeat (256) do_cycle();

        // Both requests kept high: grants must alternate, read first.
        repeat (8) begin
            do_cycle();
            if (!wr_req) issue_wr(8'($urandom_range(0, 255)), rand84(), rand84());
            if (!rd_req) issue_rd(8'($urandom_range(0, 255)));
        end
        drain();

        issue_wr(8'h2A, {21{4'h5}}, {84{1'b1}});
        do_cycle();
        issue_rd(8'h2A);
        do_cycle();
        do_cycle();

        issue_wr(8'h03, {84{1'b1}}, 84'h00F);
        do_cycle();
        issue_rd(8'h03);
        do_cycle();
        do_cycle();

        issue_wr(8'h03, {84{1'b1}}, 84'd0);
        do_cycle();
        issue_rd(8'h03);
        do_cycle();
        do_cycle();

        // Random traffic on a small address window to force collisions.
        repeat (400) begin
            if (!wr_req && $urandom_range(0, 2) == 0)
                issue_wr(8'($urandom_range(0, 15)), rand84(), rand84());
            if (!rd_req && $urandom_range(0, 2) == 0)
                issue_rd(8'($urandom_range(0, 15)));
            do_cycle();
        end
        drain();

        // Reset right after a read grant: its data beat must be dropped.
        issue_rd(8'h2A);
        do_cycle();
        RST = 1'b1;
        do_cycle();
        RST = 1'b0;
        issue_wr(8'h10, rand84(), rand84());
        issue_rd(8'h10);
        repeat (262) do_cycle();
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_reads: got %0d outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_spsram_256x84_ctrl.md
CT_SPSRAM_256X84_CTRL -- requirements
Module: ct_spsram_256x84_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SRAM address width (256 entries).
REQ-002 Parameter DATA_WIDTH, default 84, SRAM data and bit-write-enable width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports, one per line (name  direction  width  meaning):
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous active-high reset.
- wr_req  in  1  write request, held until wr_gnt.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_bmask  in  DATA_WIDTH  active-high per-bit write mask.
- wr_gnt  out  1  write accepted this cycle.
- rd_req  in  1  read request, held until rd_gnt.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_data_vld  out  1  rd_data valid.
- rd_data  out  DATA_WIDTH  read data.
- init_done  out  1  clear sweep finished.
- sram_A  out  ADDR_WIDTH  to SRAM A.
- sram_CEN  out  1  to SRAM CEN, active-low.
- sram_GWEN  out  1  to SRAM GWEN, active-low.
- sram_WEN  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- sram_D  out  DATA_WIDTH  to SRAM D.
- sram_Q  in  DATA_WIDTH  from SRAM Q, valid one cycle after a read access.

Function
REQ-005 States SHALL be INIT and RUN; RST forces INIT with sweep counter 0.
REQ-006 In INIT each cycle SHALL write zero to address = counter: CEN=0, GWEN=0, WEN all 0, D=0; counter increments by 1.
REQ-007 When counter = 255 is written, the next state SHALL be RUN; INIT lasts exactly 256 cycles; init_done=1 from the first RUN cycle onward.
REQ-008 wr_gnt and rd_gnt SHALL be 0 throughout INIT regardless of requests.
REQ-009 In RUN, grants SHALL be combinational in the same cycle as the request; at most one grant per cycle.
REQ-010 Only one requester asserting SHALL be granted immediately.
REQ-011 Both asserting SHALL be resolved round-robin: the port not granted last wins; after reset, read has priority.
REQ-012 A waiting requester SHALL be granted within 2 RUN cycles.
REQ-013 Write grant SHALL drive CEN=0, GWEN=0, A=wr_addr, D=wr_data, WEN=~wr_bmask.
REQ-014 Read grant SHALL drive CEN=0, GWEN=1, WEN all 1, A=rd_addr.
REQ-015 rd_data_vld SHALL be registered: 1 exactly the cycle after rd_gnt. rd_data SHALL equal sram_Q, and is defined only while rd_data_vld=1.
REQ-016 No grant in RUN SHALL drive CEN=1, GWEN=1, WEN all 1, A=0, D=0.
REQ-017 A read granted the cycle after a write to the same address SHALL return the newly written bits; this follows from serial SRAM access, with no bypass logic.
REQ-018 A fully zero wr_bmask SHALL still consume a grant and an SRAM cycle with WEN all 1.

Reset
REQ-019 During and after RST: state=INIT, counter=0, init_done=0, wr_gnt=0, rd_gnt=0, rd_data_vld=0, priority=read.
REQ-020 RST asserted mid-operation SHALL drop any pending rd_data_vld and restart the full 256-cycle sweep from address 0.
REQ-021 During the RST cycle itself, SRAM outputs SHALL be idle values (CEN=1).

Structure
REQ-022 Package ct_spsram_ctrl_pkg SHALL hold ADDR_WIDTH and DATA_WIDTH defaults, DEPTH=256, and the state enum {INIT, RUN}.
REQ-023 Round-robin logic SHALL be sub-module ct_rr_arb2: 2 requests, 2 one-hot grants, registered last-grant pointer, advance input.

Verification
REQ-024 Release RST with wr_req=rd_req=1 -> no grants for 256 cycles, sram_A counts 0..255 with D=0 and WEN=0, init_done rises on cycle 256.
REQ-025 RUN: single write addr 0x2A, data 0x5...5, mask all 1s; then read 0x2A -> rd_data_vld one cycle after rd_gnt, rd_data=0x5...5.
REQ-026 Both requests held continuously -> grants alternate rd, wr, rd, wr, with read first after reset.
REQ-027 Write 0x3 with mask 0x00F over data all 1s, then read 0x3 -> rd_data=0x00F (rest cleared by init).
REQ-028 Assert RST the cycle after rd_gnt -> rd_data_vld stays 0, init_done=0, sweep restarts at sram_A=0.
